// File: rtl/mux_scan_pkg.sv
// Shared widths, FSM state type and sample payload for the mux scan controller.
package mux_scan_pkg;

    localparam int unsigned N_CH  = 8;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        REPORT = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef struct packed {
        logic [SEL_W-1:0] ch;
        logic             val;
    } sample_t;

endpackage

// File: rtl/mux_scan_ctrl_next_ch_find.sv
// Combinational search for the next enabled channel: lowest set bit when first=1,
// otherwise the lowest set bit strictly above cur.
module next_ch_find
    import mux_scan_pkg::*;
(
    input  logic [N_CH-1:0]  mask,
    input  logic [SEL_W-1:0] cur,
    input  logic             first,
    output logic [SEL_W-1:0] nxt,
    output logic             found
);

    // Scan downward so the lowest qualifying index is the one left standing.
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (mask[i] && (first || (SEL_W'(i) > cur))) begin
                nxt   = SEL_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Select sequencer for an 8:1 mux tree: walks enabled channels, settles, samples, reports.
// Optional back-to-back rescans from DONE when MUX_SCAN_AUTO_EN is defined.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N_CH-1:0]  ch_mask,
    input  logic             mux_out,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             smp_valid,
    input  logic             smp_ready,
    output logic [SEL_W-1:0] smp_ch,
    output logic             smp_bit,
    output logic [N_CH-1:0]  scan_word,
    output logic             done
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

    state_t           state_q, state_d;
    logic [N_CH-1:0]  mask_q, mask_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    sample_t          smp_q, smp_d;
    logic             smp_valid_q, smp_valid_d;
    logic [N_CH-1:0]  word_q, word_d;
    logic             busy_q, done_q;

    logic             first_c;
    logic [N_CH-1:0]  find_mask_c;
    logic [SEL_W-1:0] nxt_c;
    logic             found_c;
    logic             relaunch_ok_c;

    // Search the live mask when starting a pass, the latched copy mid-scan.
    assign first_c     = (state_q == IDLE) || (state_q == DONE);
    assign find_mask_c = first_c ? ch_mask : mask_q;

    next_ch_find u_find (
        .mask  (find_mask_c),
        .cur   (sel_q),
        .first (first_c),
        .nxt   (nxt_c),
        .found (found_c)
    );

`ifdef MUX_SCAN_AUTO_EN
    assign relaunch_ok_c = (state_q == DONE);
`else
    assign relaunch_ok_c = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            cnt_q       <= '0;
            sel_q       <= '0;
            smp_q       <= '0;
            smp_valid_q <= 1'b0;
            word_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            smp_q       <= smp_d;
            smp_valid_q <= smp_valid_d;
            word_q      <= word_d;
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = found_c ? SETTLE : DONE;
            SETTLE:  if (cnt_q == '0) state_d = REPORT;
            REPORT:  if (smp_ready) state_d = found_c ? SETTLE : DONE;
            DONE:    state_d = (relaunch_ok_c && start && found_c) ? SETTLE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for the registered datapath and outputs.
    always_comb begin
        mask_d      = mask_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        smp_d       = smp_q;
        smp_valid_d = smp_valid_q;
        word_d      = word_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    word_d = '0;
                    if (found_c) begin
                        mask_d = ch_mask;
                        sel_d  = nxt_c;
                        cnt_d  = SETTLE_LOAD;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    smp_d.ch       = sel_q;
                    smp_d.val      = mux_out;
                    word_d[sel_q]  = mux_out;
                    smp_valid_d    = 1'b1;
                end
            end
            REPORT: begin
                if (smp_ready) begin
                    smp_valid_d = 1'b0;
                    if (found_c) begin
                        sel_d = nxt_c;
                        cnt_d = SETTLE_LOAD;
                    end
                end
            end
            DONE: begin
                if (state_d == SETTLE) begin
                    word_d = '0;
                    mask_d = ch_mask;
                    sel_d  = nxt_c;
                    cnt_d  = SETTLE_LOAD;
                end
            end
            default: ;
        endcase
    end

    assign sel       = sel_q;
    assign busy      = busy_q;
    assign smp_valid = smp_valid_q;
    assign smp_ch    = smp_q.ch;
    assign smp_bit   = smp_q.val;
    assign scan_word = word_q;
    assign done      = done_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: transaction-level reference model with per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mux_scan_ctrl;

    localparam int unsigned N = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       smp_ready = 1'b0;
    logic [7:0] ch_mask = 8'h00;
    logic [7:0] mux_in = 8'h00;
    logic       mux_out;
    logic [2:0] sel, smp_ch;
    logic       busy, smp_valid, smp_bit, done;
    logic [7:0] scan_word;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    assign mux_out = mux_in[sel];

    mux_scan_ctrl #(.SETTLE_CYCLES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ch_mask   (ch_mask),
        .mux_out   (mux_out),
        .sel       (sel),
        .busy      (busy),
        .smp_valid (smp_valid),
        .smp_ready (smp_ready),
        .smp_ch    (smp_ch),
        .smp_bit   (smp_bit),
        .scan_word (scan_word),
        .done      (done)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- reference model: a queue of channels still to visit ----------------
    int         chq[$];
    int         m_wait = 0;
    bit         m_busy = 0, m_valid = 0, m_done = 0;
    logic [2:0] m_sel = 3'd0, m_ch = 3'd0;
    logic       m_bit = 1'b0;
    logic [7:0] m_word = 8'h00;

    task automatic m_begin(input logic [7:0] m);
        chq.delete();
        for (int i = 0; i < 8; i++) if (m[i]) chq.push_back(i);
        m_sel   = 3'(chq[0]);
        m_wait  = int'(N);
        m_word  = 8'h00;
        m_busy  = 1;
        m_valid = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        bit was_done;
        if (!rst_n) begin
            chq.delete();
            m_wait = 0; m_busy = 0; m_valid = 0; m_done = 0;
            m_sel = 3'd0; m_ch = 3'd0; m_bit = 1'b0; m_word = 8'h00;
        end else begin
            was_done = m_done;
            m_done   = 0;
            if (was_done) begin
`ifdef MUX_SCAN_AUTO_EN
                if (start && ch_mask != 8'h00) m_begin(ch_mask);
                else m_busy = 0;
`else
                m_busy = 0;
`endif
            end else if (!m_busy) begin
                if (start) begin
                    if (ch_mask == 8'h00) begin
                        m_word = 8'h00; m_busy = 1; m_done = 1;
                    end else begin
                        m_begin(ch_mask);
                    end
                end
            end else if (m_valid) begin
                if (smp_ready) begin
                    m_valid = 0;
                    void'(chq.pop_front());
                    if (chq.size() == 0) m_done = 1;
                    else begin m_sel = 3'(chq[0]); m_wait = int'(N); end
                end
            end else if (m_wait > 0) begin
                m_wait--;
            end else begin
                m_bit         = mux_in[m_sel];
                m_word[m_sel] = m_bit;
                m_ch          = m_sel;
                m_valid       = 1;
            end
        end
    end

    // ---------------- logs used by directed scenarios ----------------
    logic [2:0] hs_ch[$];
    logic       hs_bit[$];
    int         vrise[$];
    int         n_done = 0, done_cyc = 0, busy_cnt = 0, auto_drop = 0;
    logic [7:0] sel_seen = 8'h00;
    bit         pv = 0, auto_watch = 0;

    always @(posedge clk) begin
        cyc++;
        if (rst_n && smp_valid && smp_ready) begin
            hs_ch.push_back(smp_ch);
            hs_bit.push_back(smp_bit);
        end
    end

    // Single compare process: every cycle, every output against the model.
    always @(posedge clk) begin
        #1;
        chk("sel", 8'(sel), 8'(m_sel));
        chk("busy", 8'(busy), 8'(m_busy));
        chk("smp_valid", 8'(smp_valid), 8'(m_valid));
        chk("smp_ch", 8'(smp_ch), 8'(m_ch));
        chk("smp_bit", 8'(smp_bit), 8'(m_bit));
        chk("scan_word", scan_word, m_word);
        chk("done", 8'(done), 8'(m_done));
        if (smp_valid && !pv) vrise.push_back(cyc);
        pv = smp_valid;
        if (done) begin n_done++; done_cyc = cyc; end
        if (busy) begin busy_cnt++; sel_seen[sel] = 1'b1; end
        if (auto_watch && !busy) auto_drop++;
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    int t0 = 0;

    task automatic clear_logs();
        hs_ch.delete(); hs_bit.delete(); vrise.delete();
        n_done = 0; busy_cnt = 0; sel_seen = 8'h00;
    endtask

    task automatic pulse_start(input logic [7:0] m);
        start = 1'b1; ch_mask = m; t0 = cyc + 1;
        @(negedge clk);
        start = 1'b0; ch_mask = 8'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (n_done == 0 && k < budget) begin @(negedge clk); k++; end
        if (n_done == 0) chk("timeout_done", 8'd0, 8'd1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin @(negedge clk); k++; end
        if (busy) chk("timeout_idle", 8'd1, 8'd0);
    endtask

    initial begin
        logic [7:0] bits;
        int         exp_bits[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
        int         k;

        // Reset state, while rst_n is still low.
        @(negedge clk);
        chk("rst_sel", 8'(sel), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_valid", 8'(smp_valid), 8'd0);
        chk("rst_word", scan_word, 8'd0);
        chk("rst_done", 8'(done), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Full mask over pattern A5 with ready held high.
        mux_in = 8'hA5; smp_ready = 1'b1; clear_logs();
        pulse_start(8'hFF);
        wait_done(200);
        repeat (3) @(negedge clk);
        chk("t1_nsamples", 8'(hs_ch.size()), 8'd8);
        bits = 8'h00;
        for (int i = 0; i < 8 && i < hs_ch.size(); i++) begin
            chk("t1_ch_order", 8'(hs_ch[i]), 8'(i));
            chk("t1_bit_seq", 8'(hs_bit[i]), 8'(exp_bits[i]));
            bits[i] = hs_bit[i];
        end
        chk("t1_bits", bits, 8'hA5);
        chk("t1_word", scan_word, 8'hA5);
        chk("t1_first_valid", 8'(vrise.size() > 0 ? vrise[0] - t0 : -1), 8'd2);
        chk("t1_last_valid", 8'(vrise.size() == 8 ? vrise[7] - t0 : -1), 8'd23);
        chk("t1_done_lat", 8'(done_cyc - t0), 8'd24);
        chk("t1_ndone", 8'(n_done), 8'd1);

        // Sparse mask 0x24.
        mux_in = 8'($urandom); clear_logs();
        pulse_start(8'h24);
        wait_done(200);
        repeat (2) @(negedge clk);
        chk("t2_nsamples", 8'(hs_ch.size()), 8'd2);
        if (hs_ch.size() == 2) begin
            chk("t2_ch_a", 8'(hs_ch[0]), 8'd2);
            chk("t2_ch_b", 8'(hs_ch[1]), 8'd5);
        end
        chk("t2_sel_seen", sel_seen, 8'h24);
        chk("t2_word", scan_word, mux_in & 8'h24);

        // Back-pressure for 5 cycles on channel 3.
        mux_in = 8'($urandom); clear_logs();
        pulse_start(8'hFF);
        k = 0;
        while (!(smp_valid && smp_ch == 3'd3) && k < 200) begin @(negedge clk); k++; end
        chk("t3_reach_ch3", 8'(smp_valid && smp_ch == 3'd3), 8'd1);
        smp_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("t3_hold_valid", 8'(smp_valid), 8'd1);
            chk("t3_hold_ch", 8'(smp_ch), 8'd3);
            chk("t3_hold_sel", 8'(sel), 8'd3);
            chk("t3_hold_bit", 8'(smp_bit), 8'(mux_in[3]));
        end
        smp_ready = 1'b1;
        wait_done(200);
        @(negedge clk);
        chk("t3_nsamples", 8'(hs_ch.size()), 8'd8);
        for (int i = 0; i < 8 && i < hs_ch.size(); i++) chk("t3_ch_order", 8'(hs_ch[i]), 8'(i));
        chk("t3_word", scan_word, mux_in);

        // Empty mask: immediate done, no samples.
        clear_logs();
        pulse_start(8'h00);
        repeat (3) @(negedge clk);
        chk("t4_done_lat", 8'(done_cyc - t0), 8'd0);
        chk("t4_ndone", 8'(n_done), 8'd1);
        chk("t4_nvalid", 8'(vrise.size()), 8'd0);
        chk("t4_busy_cycles", 8'(busy_cnt), 8'd1);
        chk("t4_word", scan_word, 8'h00);

        // Reset during SETTLE of channel 4, then a fresh scan.
        mux_in = 8'($urandom); clear_logs();
        pulse_start(8'hFF);
        k = 0;
        while (!(busy && sel == 3'd4 && !smp_valid) && k < 200) begin @(negedge clk); k++; end
        chk("t5_reach_ch4", 8'(busy && sel == 3'd4), 8'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_sel", 8'(sel), 8'd0);
        chk("t5_rst_busy", 8'(busy), 8'd0);
        chk("t5_rst_valid", 8'(smp_valid), 8'd0);
        chk("t5_rst_word", scan_word, 8'd0);
        @(negedge clk);
        rst_n = 1'b1; clear_logs();
        start = 1'b1; ch_mask = 8'hFF; smp_ready = 1'b0;
        k = 0;
        while (!smp_valid && k < 50) begin @(negedge clk); k++; end
        repeat (4) @(negedge clk);
        chk("t5_report_hold", 8'(smp_valid && smp_ch == 3'd0), 8'd1);
        start = 1'b0; smp_ready = 1'b1;
        wait_done(200);
        @(negedge clk);
        chk("t5_nsamples", 8'(hs_ch.size()), 8'd8);
        if (hs_ch.size() > 0) chk("t5_first_ch", 8'(hs_ch[0]), 8'd0);

`ifdef MUX_SCAN_AUTO_EN
        // Continuous rescans with start held.
        mux_in = 8'($urandom); clear_logs(); auto_watch = 1'b0;
        start = 1'b1; ch_mask = 8'h81;
        @(negedge clk);
        auto_watch = 1'b1;
        k = 0;
        while (n_done < 3 && k < 300) begin @(negedge clk); k++; end
        start = 1'b0; auto_watch = 1'b0;
        chk("t6_ndone", 8'(n_done), 8'd3);
        chk("t6_busy_drop", 8'(auto_drop), 8'd0);
        for (int i = 0; i < 6 && i < hs_ch.size(); i++)
            chk("t6_ch_seq", 8'(hs_ch[i]), (i % 2 == 0) ? 8'd0 : 8'd7);
        wait_idle(100);
`endif

        // Randomized traffic, including back-pressure, mask churn and resets.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            smp_ready = ($urandom_range(3) != 0);
            ch_mask   = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
            start     = ($urandom_range(5) == 0);
            if ($urandom_range(3) == 0) mux_in = 8'($urandom);
            if ($urandom_range(400) == 0) begin
                rst_n = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
            end
        end
        @(negedge clk);
        start = 1'b0; smp_ready = 1'b1;
        wait_idle(200);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
